// File: rtl/rcc_pkg.sv
// Shared RCC definitions for the ETH kernel-clock switch sequencer:
// state encoding, default wait constants and a small sizing helper.
package rcc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GATE_OFF = 3'd1,
        ST_SWITCH   = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_GATE_ON  = 3'd4,
        ST_ERR      = 3'd5,
        ST_ACK      = 3'd6
    } rcc_eth_sw_state_e;

    localparam int RCC_ETH_GATE_WAIT   = 4;
    localparam int RCC_ETH_SW_TIMEOUT  = 64;
    localparam int RCC_ETH_SETTLE_WAIT = 4;
    localparam int RCC_ETH_CNT_W       = 8;

    // Largest of the three wait lengths; the counter never reaches this value.
    function automatic int rcc_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/rcc_eth_clk_switch_seq_chk.sv
// Property checker for the ETH clock switch sequencer: busy tracks the
// state, the ack is a single-cycle pulse, selects move only at the two
// legal points, and the wait counter stays below its largest terminal count.
module rcc_eth_clk_switch_seq_chk
    import rcc_pkg::*;
#(
    parameter int CNT_W     = RCC_ETH_CNT_W,
    parameter int CNT_LIMIT = RCC_ETH_SW_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  rcc_eth_sw_state_e state,
    input  logic              busy,
    input  logic              req_ack,
    input  logic              eth_fes_o,
    input  logic              eth_epis_2_o,
    input  logic [CNT_W-1:0]  cnt
);

    a_busy_matches_state : assert property (
        @(posedge clk) disable iff (!rst_n) busy == (state != ST_IDLE));

    a_ack_one_cycle : assert property (
        @(posedge clk) disable iff (!rst_n) req_ack |=> !req_ack);

    a_sel_change_legal : assert property (
        @(posedge clk) disable iff (!rst_n)
        ((eth_fes_o != $past(eth_fes_o)) || (eth_epis_2_o != $past(eth_epis_2_o)))
        |-> (($past(state) == ST_GATE_OFF) || ($past(state) == ST_ERR)));

    a_cnt_bounded : assert property (
        @(posedge clk) disable iff (!rst_n) int'(cnt) < CNT_LIMIT);

endmodule

// File: rtl/rcc_eth_clk_switch_seq.sv
// ETH kernel-clock reconfiguration sequencer. On a MAC request that changes
// fes/epis_2 it gates the MII clocks, swaps the selects, waits for the
// glitch-free switches, settles, ungates and acks. A request without a
// change is acked immediately; a switch timeout reverts the selects and
// raises a sticky error.
module rcc_eth_clk_switch_seq
    import rcc_pkg::*;
#(
    parameter int GATE_WAIT   = RCC_ETH_GATE_WAIT,
    parameter int SW_TIMEOUT  = RCC_ETH_SW_TIMEOUT,
    parameter int SETTLE_WAIT = RCC_ETH_SETTLE_WAIT,
    parameter int CNT_W       = RCC_ETH_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic req_fes,
    input  logic req_epis_2,
    input  logic clk_en_req,
    input  logic sw_done,
    input  logic err_clr,
    output logic req_ack,
    output logic busy,
    output logic eth_clk_gate_en,
    output logic eth_fes_o,
    output logic eth_epis_2_o,
    output logic sw_err
);

    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] SW_LAST    = CNT_W'(SW_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_WAIT - 1);

    rcc_eth_sw_state_e state;
    logic [CNT_W-1:0]  cnt;
    logic              gate_allow;
    logic              lat_fes;
    logic              lat_epis_2;
    logic              prev_fes;
    logic              prev_epis_2;

    // Functional enable is honoured only while the sequencer allows the gates open.
    assign eth_clk_gate_en = clk_en_req & gate_allow;

    // Sequencer state, wait counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_ack      <= 1'b0;
            busy         <= 1'b0;
            gate_allow   <= 1'b1;
            eth_fes_o    <= 1'b0;
            eth_epis_2_o <= 1'b0;
            sw_err       <= 1'b0;
            lat_fes      <= 1'b0;
            lat_epis_2   <= 1'b0;
            prev_fes     <= 1'b0;
            prev_epis_2  <= 1'b0;
        end else begin
            req_ack <= 1'b0;
            // A timeout in ERR below overrides a same-cycle clear.
            if (err_clr) begin
                sw_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        busy <= 1'b1;
                        if ((req_fes != eth_fes_o) || (req_epis_2 != eth_epis_2_o)) begin
                            state       <= ST_GATE_OFF;
                            gate_allow  <= 1'b0;
                            lat_fes     <= req_fes;
                            lat_epis_2  <= req_epis_2;
                            prev_fes    <= eth_fes_o;
                            prev_epis_2 <= eth_epis_2_o;
                        end else begin
                            state   <= ST_ACK;
                            req_ack <= 1'b1;
                        end
                    end
                end
                ST_GATE_OFF: begin
                    if (cnt == GATE_LAST) begin
                        state        <= ST_SWITCH;
                        eth_fes_o    <= lat_fes;
                        eth_epis_2_o <= lat_epis_2;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SWITCH: begin
                    if (sw_done) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                    end else if (cnt == SW_LAST) begin
                        state <= ST_ERR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    // Gates reopen on GATE_ON entry so the gated window is exactly
                    // GATE_OFF + SWITCH + SETTLE cycles.
                    if (cnt == SETTLE_LAST) begin
                        state      <= ST_GATE_ON;
                        gate_allow <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_GATE_ON: begin
                    state      <= ST_ACK;
                    gate_allow <= 1'b1;
                    req_ack    <= 1'b1;
                end
                ST_ERR: begin
                    state        <= ST_ACK;
                    sw_err       <= 1'b1;
                    eth_fes_o    <= prev_fes;
                    eth_epis_2_o <= prev_epis_2;
                    gate_allow   <= 1'b1;
                    req_ack      <= 1'b1;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    gate_allow <= 1'b1;
                    cnt        <= '0;
                end
            endcase
        end
    end

    rcc_eth_clk_switch_seq_chk #(
        .CNT_W     (CNT_W),
        .CNT_LIMIT (rcc_max3(GATE_WAIT, SW_TIMEOUT, SETTLE_WAIT))
    ) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .busy         (busy),
        .req_ack      (req_ack),
        .eth_fes_o    (eth_fes_o),
        .eth_epis_2_o (eth_epis_2_o),
        .cnt          (cnt)
    );

endmodule

// File: tb/tb_rcc_eth_clk_switch_seq.sv
// Directed bench for the ETH clock switch sequencer. Inputs are driven on
// the falling edge; outputs are sampled on the falling edge, k cycles after
// the cycle in which a request was presented.
module tb_rcc_eth_clk_switch_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic req_fes;
    logic req_epis_2;
    logic clk_en_req;
    logic sw_done;
    logic err_clr;
    logic req_ack;
    logic busy;
    logic eth_clk_gate_en;
    logic eth_fes_o;
    logic eth_epis_2_o;
    logic sw_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rcc_eth_clk_switch_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_fes         (req_fes),
        .req_epis_2      (req_epis_2),
        .clk_en_req      (clk_en_req),
        .sw_done         (sw_done),
        .err_clr         (err_clr),
        .req_ack         (req_ack),
        .busy            (busy),
        .eth_clk_gate_en (eth_clk_gate_en),
        .eth_fes_o       (eth_fes_o),
        .eth_epis_2_o    (eth_epis_2_o),
        .sw_err          (sw_err)
    );

    task automatic test_reset();
        logic [5:0] outs;
        rst_n = 1'b0; req = 1'b0; req_fes = 1'b0; req_epis_2 = 1'b0;
        clk_en_req = 1'b1; sw_done = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        outs = {req_ack, busy, eth_fes_o, eth_epis_2_o, sw_err, eth_clk_gate_en};
        n_checks++;
        if (outs !== 6'b000001) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", outs, 6'b000001);
        end
        clk_en_req = 1'b0; #1;
        n_checks++;
        if (eth_clk_gate_en !== 1'b0) begin
            n_fail++; $display("FAIL gate_follows_en_low: got %b expected 0", eth_clk_gate_en);
        end
        clk_en_req = 1'b1; #1;
        n_checks++;
        if (eth_clk_gate_en !== 1'b1) begin
            n_fail++; $display("FAIL gate_follows_en_high: got %b expected 1", eth_clk_gate_en);
        end
    endtask

    // fes 0->1, sw_done arrives on the third SWITCH cycle; req dropped and req_fes
    // changed right after the latch.
    task automatic test_fes_switch();
        int low_cnt = 0;
        int ack_k   = -1;
        int ack_cnt = 0;
        @(negedge clk);
        req = 1'b1; req_fes = 1'b1; req_epis_2 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!eth_clk_gate_en) low_cnt++;
            if (req_ack) begin ack_cnt++; ack_k = k; end
            if (k == 4) begin
                n_checks++;
                if (eth_fes_o !== 1'b0) begin
                    n_fail++; $display("FAIL fes_before_switch: got %b expected 0", eth_fes_o);
                end
            end
            if (k == 5) begin
                n_checks++;
                if (eth_fes_o !== 1'b1) begin
                    n_fail++; $display("FAIL fes_at_switch: got %b expected 1", eth_fes_o);
                end
            end
            if (k == 13 || k == 14) begin
                n_checks++;
                if (busy !== (k == 13)) begin
                    n_fail++; $display("FAIL fes_busy_k%0d: got %b expected %b", k, busy, (k == 13));
                end
            end
            if (k == 1) begin req = 1'b0; req_fes = 1'b0; end
            sw_done = (k == 7);
        end
        n_checks++;
        if (low_cnt !== 11) begin
            n_fail++; $display("FAIL fes_gate_low_cycles: got %0d expected 11", low_cnt);
        end
        n_checks++;
        if (ack_k !== 13 || ack_cnt !== 1) begin
            n_fail++; $display("FAIL fes_ack: got cycle %0d count %0d expected cycle 13 count 1", ack_k, ack_cnt);
        end
        n_checks++;
        if ({eth_fes_o, eth_epis_2_o} !== 2'b10) begin
            n_fail++; $display("FAIL fes_final_sel: got %b expected 10", {eth_fes_o, eth_epis_2_o});
        end
    endtask

    // Request matching current selects: immediate ack, gates untouched.
    task automatic test_same_sel();
        int low_cnt = 0;
        @(negedge clk);
        req = 1'b1; req_fes = 1'b1; req_epis_2 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (!eth_clk_gate_en) low_cnt++;
            if (k <= 2) begin
                n_checks++;
                if ({req_ack, busy} !== ((k == 1) ? 2'b11 : 2'b00)) begin
                    n_fail++; $display("FAIL same_ack_busy_k%0d: got %b expected %b", k, {req_ack, busy},
                                       ((k == 1) ? 2'b11 : 2'b00));
                end
            end
            req = 1'b0;
        end
        n_checks++;
        if (low_cnt !== 0) begin
            n_fail++; $display("FAIL same_gate_dropped: got %0d low cycles expected 0", low_cnt);
        end
    endtask

    // sw_done never comes: 64 SWITCH cycles, ERR, revert, sticky error.
    // err_clr pulsed in the ERR cycle must lose to the set.
    task automatic test_timeout();
        int low_cnt = 0;
        int ack_k   = -1;
        @(negedge clk);
        req = 1'b1; req_fes = 1'b1; req_epis_2 = 1'b1; sw_done = 1'b0;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (!eth_clk_gate_en) low_cnt++;
            if (req_ack) ack_k = k;
            if (k == 5 || k == 70) begin
                n_checks++;
                if (eth_epis_2_o !== (k == 5)) begin
                    n_fail++; $display("FAIL to_epis_k%0d: got %b expected %b", k, eth_epis_2_o, (k == 5));
                end
            end
            if (k == 69 || k == 70) begin
                n_checks++;
                if (sw_err !== (k == 70)) begin
                    n_fail++; $display("FAIL to_sw_err_k%0d: got %b expected %b", k, sw_err, (k == 70));
                end
            end
            req = 1'b0;
            err_clr = (k == 69);
        end
        n_checks++;
        if (low_cnt !== 69 || ack_k !== 70) begin
            n_fail++; $display("FAIL to_timing: got low %0d ack %0d expected low 69 ack 70", low_cnt, ack_k);
        end
        n_checks++;
        if ({sw_err, eth_fes_o, eth_epis_2_o} !== 3'b110) begin
            n_fail++; $display("FAIL to_sticky_sel: got %b expected 110", {sw_err, eth_fes_o, eth_epis_2_o});
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (sw_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clr: got %b expected 0", sw_err);
        end
    endtask

    // Reset asserted in SWITCH with new selects already applied.
    task automatic test_async_reset();
        @(negedge clk);
        req = 1'b1; req_fes = 1'b1; req_epis_2 = 1'b1; sw_done = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req = 1'b0;
        end
        n_checks++;
        if ({busy, eth_clk_gate_en, eth_epis_2_o} !== 3'b101) begin
            n_fail++; $display("FAIL ar_in_switch: got %b expected 101", {busy, eth_clk_gate_en, eth_epis_2_o});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, eth_clk_gate_en, eth_fes_o, eth_epis_2_o} !== 4'b0100) begin
            n_fail++; $display("FAIL ar_async: got %b expected 0100",
                               {busy, eth_clk_gate_en, eth_fes_o, eth_epis_2_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // req held through ack with a new epis_2: one IDLE cycle, then a new sequence.
    task automatic test_back_to_back();
        int ack_cnt = 0;
        int ack_k   = -1;
        @(negedge clk);
        req = 1'b1; req_fes = 1'b0; req_epis_2 = 1'b1; sw_done = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (req_ack) begin
                ack_cnt++;
                if (ack_cnt == 1) begin
                    n_checks++;
                    if (k !== 11) begin
                        n_fail++; $display("FAIL b2b_first_ack: got cycle %0d expected 11", k);
                    end
                end
                ack_k = k;
            end
            if (k == 12 || k == 13) begin
                n_checks++;
                if ({busy, eth_clk_gate_en} !== ((k == 12) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL b2b_k%0d: got %b expected %b", k, {busy, eth_clk_gate_en},
                                       ((k == 12) ? 2'b01 : 2'b10));
                end
            end
            if (k == 11) req_epis_2 = 1'b0;
            if (k == 13) req = 1'b0;
        end
        sw_done = 1'b0;
        n_checks++;
        if (ack_cnt !== 2 || ack_k !== 23) begin
            n_fail++; $display("FAIL b2b_second_ack: got count %0d cycle %0d expected 2 and 23", ack_cnt, ack_k);
        end
        n_checks++;
        if ({eth_fes_o, eth_epis_2_o} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_final_sel: got %b expected 00", {eth_fes_o, eth_epis_2_o});
        end
    endtask

    initial begin
        test_reset();
        test_fes_switch();
        test_same_sel();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
